// File: rtl/pov_spi_loader_pkg.sv
// Shared fixed-point widths, POV frame layout and reset vectors.
// Q8.8 signed vectors; a frame is six of them, playerX first.
package pov_spi_loader_pkg;

  localparam int QM = 8;
  localparam int QN = 8;
  localparam int QMN = QM + QN;
  localparam int FRAME_BITS = 6 * QMN;
  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef logic [QMN-1:0] fx_t;

  // first member lands in the MSBs, matching first-sent-first order
  typedef struct packed {
    fx_t px;
    fx_t py;
    fx_t fx;
    fx_t fy;
    fx_t vx;
    fx_t vy;
  } pov_t;

  localparam fx_t POV_RESET_PX = 16'h0180;
  localparam fx_t POV_RESET_PY = 16'h0180;
  localparam fx_t POV_RESET_FX = 16'h0100;
  localparam fx_t POV_RESET_FY = 16'h0000;
  localparam fx_t POV_RESET_VX = 16'h0000;
  localparam fx_t POV_RESET_VY = 16'h0080;

  localparam pov_t POV_RESET = {
    POV_RESET_PX, POV_RESET_PY,
    POV_RESET_FX, POV_RESET_FY,
    POV_RESET_VX, POV_RESET_VY
  };

endpackage

// File: rtl/pov_spi_loader_sync_edge.sv
// Pin synchroniser with registered rise/fall pulses.
// level is delayed to stay aligned with the pulses.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;

  // sync chain plus one-cycle edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], d};
      level <= sync[SYNC_STAGES-1];
      rise  <= sync[SYNC_STAGES-1] & ~level;
      fall  <= ~sync[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/pov_spi_loader.sv
// SPI slave loading the six POV vectors, committed on load_new.
// Optional MISO readback of live vectors: POV_READBACK_EN.
module pov_spi_loader
  import pov_spi_loader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_sclk,
  input  logic           i_mosi,
  input  logic           i_ss_n,
  output logic           o_miso,
  input  logic           load_new,
  output logic [QMN-1:0] playerX,
  output logic [QMN-1:0] playerY,
  output logic [QMN-1:0] facingX,
  output logic [QMN-1:0] facingY,
  output logic [QMN-1:0] vplaneX,
  output logic [QMN-1:0] vplaneY,
  output logic           o_pending,
  output logic           o_frame_err
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVR = CNT_W'(FRAME_BITS + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic [SYNC_STAGES:0] mosi_sync;
  logic mosi_s;

  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0] bitcnt;
  logic armed;
  pov_t pend_buf;
  pov_t live;
  logic stage;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .reset(reset), .d(i_sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .reset(reset), .d(i_ss_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  // mosi gets one extra flop to line up with the edge pulses
  always_ff @(posedge clk) begin
    if (reset) mosi_sync <= '0;
    else mosi_sync <= {mosi_sync[SYNC_STAGES-1:0], i_mosi};
  end

  assign mosi_s = mosi_sync[SYNC_STAGES];
  assign stage = armed && ss_rise && (bitcnt == CNT_FULL);

  // shift, frame end, arming, staging and commit
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= '0;
      bitcnt      <= '0;
      armed       <= 1'b0;
      pend_buf    <= POV_RESET;
      live        <= POV_RESET;
      o_pending   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      // first observed ss_n rise arms; a transfer open at reset is dropped
      if (ss_rise) armed <= 1'b1;
      if (armed) begin
        if (ss_fall) begin
          bitcnt <= '0;
        end else if (ss_rise) begin
          bitcnt <= '0;
          if (bitcnt == CNT_FULL) begin
            pend_buf    <= pov_t'(shreg);
            o_frame_err <= 1'b0;
          end else begin
            o_frame_err <= 1'b1;
          end
        end else if (!ss_lvl && sclk_rise) begin
          shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
          if (bitcnt != CNT_OVR) bitcnt <= bitcnt + 1'b1;
        end
      end
      if (load_new && o_pending) live <= pend_buf;
      if (stage) o_pending <= 1'b1;
      else if (load_new) o_pending <= 1'b0;
    end
  end

`ifdef POV_READBACK_EN
  logic [FRAME_BITS-1:0] rb;

  // readback snapshot of live vectors, shifted out on sclk fall
  always_ff @(posedge clk) begin
    if (reset) rb <= '0;
    else if (armed && ss_fall) rb <= live;
    else if (!ss_lvl && sclk_fall) rb <= {rb[FRAME_BITS-2:0], 1'b0};
  end

  assign o_miso = rb[FRAME_BITS-1];
`else
  assign o_miso = 1'b0;
`endif

  assign playerX = live.px;
  assign playerY = live.py;
  assign facingX = live.fx;
  assign facingY = live.fy;
  assign vplaneX = live.vx;
  assign vplaneY = live.vy;

endmodule

// File: tb/tb_pov_spi_loader.sv
// Randomised bench for pov_spi_loader against a frame-level model.
// Define POV_READBACK_EN to also check the MISO bitstream.
module tb_pov_spi_loader;

  localparam int FB = 96;
  localparam int HP = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic ss_n = 1'b1;
  logic load_new = 1'b0;
  logic miso;
  logic [15:0] px, py, fx, fy, vx, vy;
  logic pending, ferr;

  int n_checks = 0;
  int n_errors = 0;

  logic [FB-1:0] m_live, m_pend;
  logic m_pending, m_err;
  logic [127:0] rx;

  localparam logic [FB-1:0] RST_V =
    {16'h0180, 16'h0180, 16'h0100, 16'h0000, 16'h0000, 16'h0080};

  pov_spi_loader dut (
    .clk(clk), .reset(reset),
    .i_sclk(sclk), .i_mosi(mosi), .i_ss_n(ss_n),
    .o_miso(miso), .load_new(load_new),
    .playerX(px), .playerY(py),
    .facingX(fx), .facingY(fy),
    .vplaneX(vx), .vplaneY(vy),
    .o_pending(pending), .o_frame_err(ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic logic [FB-1:0] q(input real a, input real b,
                                      input real c, input real d,
                                      input real e, input real f);
    logic [15:0] v[6];
    v[0] = 16'($rtoi(a * 256.0));
    v[1] = 16'($rtoi(b * 256.0));
    v[2] = 16'($rtoi(c * 256.0));
    v[3] = 16'($rtoi(d * 256.0));
    v[4] = 16'($rtoi(e * 256.0));
    v[5] = 16'($rtoi(f * 256.0));
    return {v[0], v[1], v[2], v[3], v[4], v[5]};
  endfunction

  // frame-level model: a transfer either stages or flags an error
  task automatic m_xfer(input logic [127:0] d, input int n);
    if (n == FB) begin
      m_pend = d[FB-1:0];
      m_pending = 1'b1;
      m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic m_load();
    if (m_pending) begin
      m_live = m_pend;
      m_pending = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_live = RST_V;
    m_pend = RST_V;
    m_pending = 1'b0;
    m_err = 1'b0;
  endtask

  // send n bits MSB first; leaves ss_n just raised
  task automatic xfer(input logic [127:0] d, input int n);
    rx = '0;
    ss_n = 1'b0;
    tick(HP);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      tick(HP);
      rx = {rx[126:0], miso};
      sclk = 1'b1;
      tick(HP);
      sclk = 1'b0;
    end
    tick(HP);
    ss_n = 1'b1;
  endtask

  task automatic pulse_load();
    load_new = 1'b1;
    tick(1);
    load_new = 1'b0;
    tick(4);
    m_load();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".live"}, {32'h0, px, py, fx, fy, vx, vy}, {32'h0, m_live});
    check({tag, ".pend"}, {127'h0, pending}, {127'h0, m_pending});
    check({tag, ".err"}, {127'h0, ferr}, {127'h0, m_err});
  endtask

  task automatic full(input logic [127:0] d, input int n);
    xfer(d, n);
    tick(8);
    m_xfer(d, n);
  endtask

  initial begin
    logic [FB-1:0] fa, fb2, fc, fd, fe, f2;
    logic [127:0] rnd;
    int n;

    m_reset();
    tick(3);
    reset = 1'b0;
    tick(8);
    check_all("t1_reset");
    check("t1_miso", {127'h0, miso}, 128'h0);

    f2 = q(3.25, 7.5, 0.0, -1.0, 0.5, 0.0);
    check("t2_const", {32'h0, f2},
          {32'h0, 16'h0340, 16'h0780, 16'h0000,
           16'hff00, 16'h0080, 16'h0000});
    full({32'h0, f2}, FB);
    check_all("t2_staged");
    pulse_load();
    check_all("t2_commit");

`ifdef POV_READBACK_EN
    full('0, FB);
    check("t6_miso", {32'h0, rx[FB-1:0]}, {32'h0, f2});
    check_all("t6_after");
    pulse_load();
    check_all("t6_load");
`endif

    full({$urandom, $urandom, $urandom, $urandom}, FB - 1);
    check_all("t3_short");
    full({$urandom, $urandom, $urandom, $urandom}, FB + 3);
    check_all("t3_long");
    full('0, 0);
    check_all("t3_empty");

    fa = {$urandom, $urandom, $urandom};
    fb2 = {$urandom, $urandom, $urandom};
    full({32'h0, fa}, FB);
    full({32'h0, fb2}, FB);
    check_all("t4_ab");
    pulse_load();
    check_all("t4_loadb");

    // frame C completes in the load_new cycle with nothing pending
    fc = {$urandom, $urandom, $urandom};
    xfer({32'h0, fc}, FB);
    tick(3);
    load_new = 1'b1;
    tick(1);
    load_new = 1'b0;
    m_load();
    m_xfer({32'h0, fc}, FB);
    tick(6);
    check_all("t4_simc");
    pulse_load();
    check_all("t4_loadc");

    // E completes in the load_new cycle while D is pending
    fd = {$urandom, $urandom, $urandom};
    fe = {$urandom, $urandom, $urandom};
    full({32'h0, fd}, FB);
    xfer({32'h0, fe}, FB);
    tick(3);
    load_new = 1'b1;
    tick(1);
    load_new = 1'b0;
    m_load();
    m_xfer({32'h0, fe}, FB);
    tick(6);
    check_all("t4_simd");
    pulse_load();
    check_all("t4_loade");

    // reset in the middle of a transfer
    ss_n = 1'b0;
    tick(HP);
    for (int i = 0; i < FB; i++) begin
      if (i == FB / 2) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        m_reset();
      end
      mosi = 1'($urandom);
      tick(HP);
      sclk = 1'b1;
      tick(HP);
      sclk = 1'b0;
    end
    tick(HP);
    ss_n = 1'b1;
    tick(8);
    check_all("t5_rst");
    fa = {$urandom, $urandom, $urandom};
    full({32'h0, fa}, FB);
    check_all("t5_good");
    pulse_load();
    check_all("t5_load");

    for (int it = 0; it < 30; it++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 5))
        0: n = FB - 1;
        1: n = FB + 1;
        2: n = $urandom_range(0, 20);
        default: n = FB;
      endcase
      full(rnd, n);
      check_all("rnd_xfer");
      if ($urandom_range(0, 1) == 1) begin
        pulse_load();
        check_all("rnd_load");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
